// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the serial adder sequencer
package serial_add_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_slice.sv
// rtl/serial_add_slice.sv - 1-bit full adder with its carry flop
module serial_add_slice (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic cin,
  input  logic a,
  input  logic b,
  input  logic en,
  output logic s,
  output logic cout
);

  logic carry_q;

  always_comb begin
    s    = a ^ b ^ carry_q;
    cout = (a & b) | (a & carry_q) | (b & carry_q);
  end

  // load has priority so an accept always starts from the new carry-in
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= cin;
    end else if (en) begin
      carry_q <= cout;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - parallel-word sequencer driving the bit-serial adder slice
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH:0]   result_q;
  logic             done_q;
  logic             ready_q;
  logic             busy_q;
  logic             accept;
  logic             run;
  logic             s;
  logic             cout;

  assign accept = start & ready_q;
  assign run    = (state_q == ST_RUN);

  serial_add_slice u_slice (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .cin  (cin),
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .en   (run),
    .s    (s),
    .cout (cout)
  );

  // new sum bit enters at the MSB so the LSB-first stream lands in order
  always_comb begin
    sum_d = WIDTH'({s, sum_q} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (accept) begin
        sa_q    <= op_a;
        sb_q    <= op_b;
        cnt_q   <= '0;
        state_q <= ST_RUN;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          ST_RUN: begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            sum_q <= sum_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_q <= {cout, sum_d};
              state_q  <= ST_DONE;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=1)
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op_a = '0;
  logic [3:0] op_b = '0;
  logic       cin = 1'b0;
  logic       ready, busy, done;
  logic [4:0] result;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       ready1, busy1, done1;
  logic [1:0] result1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp, input string tag);
    int n;
    int bc;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1 && ready === 1'b0) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 5);
    chk({tag, " result"}, int'(result), int'(exp));
    chk({tag, " busy cycles"}, bc, 4);
    @(posedge clk); #1;
    chk({tag, " done width"}, int'(done), 0);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic c);
    int n;
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w1 latency", n, 2);
    chk("w1 result", int'(result1), int'(a) + int'(b) + int'(c));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int held;
    int seen;
    logic [3:0] ra, rb;
    logic       rc;

    vecs[0] = '{4'b1111, 4'b1100, 1'b0, 5'd27};
    vecs[1] = '{4'b1000, 4'b0110, 1'b1, 5'd15};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 5'd31};
    vecs[3] = '{4'd0,    4'd0,    1'b0, 5'd0};
    vecs[4] = '{4'd0,    4'd0,    1'b1, 5'd1};
    vecs[5] = '{4'd15,   4'd0,    1'b1, 5'd16};
    vecs[6] = '{4'd10,   4'd5,    1'b0, 5'd15};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", int'(ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    chk("reset w1 ready", int'(ready1), 1);
    chk("reset w1 result", int'(result1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, $sformatf("vec%0d", i));

    // back-to-back: start held in the DONE cycle
    op_a = 4'd15; op_b = 4'd12; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(ready === 1'b1 && busy === 1'b0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b reach done state", n, 4);
    chk("b2b first result", int'(result), 27);
    op_a = 4'd3; op_b = 4'd4; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b first done", int'(done), 1);
    chk("b2b no idle gap", int'(busy), 1);
    chk("b2b result at done", int'(result), 27);
    @(posedge clk); #1;
    n = 1; held = 1;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1 && result !== 5'd27) held = 0;
      @(posedge clk); #1;
      n++;
    end
    chk("b2b second latency", n, 5);
    chk("b2b result held while running", held, 1);
    chk("b2b second result", int'(result), 7);
    @(posedge clk); #1;

    // start pulse during RUN cycle 2 must be ignored
    op_a = 4'd8; op_b = 4'd6; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op_a = 4'd9; op_b = 4'd9; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignore latency", n, 5);
    chk("ignore result", int'(result), 15);
    @(posedge clk); #1;

    // reset in RUN cycle 3 aborts the op
    op_a = 4'd15; op_b = 4'd15; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort ready", int'(ready), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort result", int'(result), 0);
    chk("abort done", int'(done), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    chk("abort no done", seen, 0);
    run_op(4'd5, 4'd9, 1'b0, 5'd14, "post-abort");

    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(ra, rb, rc, ref_sum(ra, rb, rc), $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      run_op1(i[2], i[1], i[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
